// File: rtl/clock_div_pkg.sv
// Shared constants for the programmable clock divider.
package clock_div_pkg;

  localparam int CLOCK_DIV_W = 3;

  // Smallest ratio that produces a toggling output; 0 and 1 disable the divider.
  localparam int CLOCK_DIV_MIN_RATIO = 2;

endpackage

// File: rtl/clock_div.sv
// Programmable integer clock divider: q is a registered square wave of period div_r cycles,
// high for ceil(N/2) cycles, with ratio changes applied only at period boundaries.
module clock_div
  import clock_div_pkg::*;
#(
  parameter int W = CLOCK_DIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] div,
  output logic         q
);

  logic [W-1:0] cnt;
  logic [W-1:0] div_r;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] div_nxt;
  logic [W:0]   half_nxt;
  logic         active;
  logic         wrap;
  logic         q_nxt;

  always_comb begin
    cnt_nxt  = cnt + W'(1);
    div_nxt  = div_r;
    active   = (div_r >= W'(CLOCK_DIV_MIN_RATIO));
    wrap     = (cnt == div_r - W'(1));
    if (!active || wrap) begin
      div_nxt = div;
      cnt_nxt = '0;
    end
    // High phase length is taken from the ratio in force after this edge, at W+1 bits.
    half_nxt = ({1'b0, div_nxt} + (W+1)'(1)) >> 1;
    q_nxt    = (div_nxt >= W'(CLOCK_DIV_MIN_RATIO)) && ({1'b0, cnt_nxt} < half_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      div_r <= '0;
      q     <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      div_r <= div_nxt;
      q     <= q_nxt;
    end
  end

endmodule

// File: tb/tb_clock_div.sv
// Directed bench for clock_div: per-edge expected q vectors plus period/duty and disabled-state checks.
module tb_clock_div;

  localparam int W = 3;

  typedef struct packed {
    logic         reset;
    logic [W-1:0] div;
    logic         q;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] div = '0;
  logic         q;

  int n_checks = 0;
  int n_fails  = 0;
  vec_t vecs[$];

  clock_div #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .div   (div),
    .q     (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic r, input int d, input logic e);
    vec_t v;
    v.reset = r;
    v.div   = W'(d);
    v.q     = e;
    vecs.push_back(v);
  endtask

  // Push reps copies of an n-bit pattern, MSB first.
  task automatic push_pat(input int d, input logic [7:0] pat, input int n, input int reps);
    for (int r = 0; r < reps; r++)
      for (int b = n - 1; b >= 0; b--)
        push(1'b0, d, pat[b]);
  endtask

  task automatic step(input logic r, input logic [W-1:0] d);
    @(negedge clk);
    reset = r;
    div   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic measure_period(input int n);
    int rises[$];
    int highs;
    logic prev;
    step(1'b1, W'(n));
    prev  = q;
    highs = 0;
    for (int c = 0; c < 4 * n + 1; c++) begin
      step(1'b0, W'(n));
      if (q && !prev) rises.push_back(c);
      if (q && rises.size() == 1) highs++;
      prev = q;
    end
    check($sformatf("rise_count_div%0d", n), rises.size(), 5);
    check($sformatf("first_rise_div%0d", n), (rises.size() > 0) ? rises[0] : -1, 0);
    for (int k = 1; k < rises.size(); k++)
      check($sformatf("period_div%0d_%0d", n, k), rises[k] - rises[k-1], n);
    check($sformatf("high_len_div%0d", n), highs, n / 2);
  endtask

  initial begin
    // Reset, then div=2 for 20 cycles.
    push(1'b1, 2, 1'b0);
    push(1'b1, 2, 1'b0);
    push_pat(2, 8'b10, 2, 10);
    push_pat(3, 8'b110, 3, 2);
    push_pat(5, 8'b11100, 5, 2);
    push_pat(7, 8'b1111000, 7, 2);
    push_pat(4, 8'b1100, 4, 2);
    push_pat(6, 8'b111000, 6, 2);
    // 7 -> 2 while cnt=1: old period finishes (1,1,0,0,0) before the 1,0 pattern.
    push_pat(7, 8'b11, 2, 1);
    push_pat(2, 8'b11000, 5, 1);
    push_pat(2, 8'b10, 2, 2);
    // Disabled ratios, then 3 takes effect on the next edge.
    push_pat(0, 8'b0000, 4, 1);
    push_pat(1, 8'b000, 3, 1);
    push_pat(3, 8'b110, 3, 1);
    // Reset mid-high with div=5, then a full 3/2 period restarts.
    push_pat(5, 8'b11, 2, 1);
    push(1'b1, 5, 1'b0);
    push_pat(5, 8'b11100, 5, 1);
    push(1'b0, 5, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].reset, vecs[i].div);
      check($sformatf("vec%0d_div%0d_q", i, vecs[i].div), int'(q), int'(vecs[i].q));
    end

    measure_period(4);
    measure_period(6);

    // Disabled ratio keeps the counter parked at zero.
    step(1'b1, W'(0));
    for (int c = 0; c < 3; c++) begin
      step(1'b0, W'(c % 2));
      check($sformatf("disabled_cnt_%0d", c), int'(dut.cnt), 0);
      check($sformatf("disabled_q_%0d", c), int'(q), 0);
    end
    step(1'b0, W'(3));
    check("enable_from_disabled_q", int'(q), 1);
    check("enable_from_disabled_cnt", int'(dut.cnt), 0);

    // Maximum ratio: one period of 4 high / 3 low, cnt peaks at 6.
    step(1'b1, W'(7));
    for (int c = 0; c < 7; c++) begin
      step(1'b0, W'(7));
      check($sformatf("max_ratio_cnt_%0d", c), int'(dut.cnt), c);
      check($sformatf("max_ratio_q_%0d", c), int'(q), (c < 4) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
